// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encodings,
// port-index constants, default bus widths and a saturating counter helper.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  // FSM states kept as plain vectors so older tools and netlists see fixed codes.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;

  // Round-robin pointer values: which port wins a tie.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Hold counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signals of the arbiter.
// slave modport = arbiter side, master modport = requesters and RAM.
// Optional write protection (WP / A_WERR) exists only with RAM_ARB_WP_EN.
interface ram_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              A_REQ, A_WE, A_LOCK;
  logic [ADDR_W-1:0] A_ADDR;
  logic [DATA_W-1:0] A_WDATA;
  logic              A_GNT, A_RVALID;

  logic              B_REQ, B_WE, B_LOCK;
  logic [ADDR_W-1:0] B_ADDR;
  logic [DATA_W-1:0] B_WDATA;
  logic              B_GNT, B_RVALID;

  logic [DATA_W-1:0] RDATA;

  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_DIN;
  logic              RAM_RI;
  logic [DATA_W-1:0] RAM_DOUT;

`ifdef RAM_ARB_WP_EN
  logic [1:0]        WP;
  logic              A_WERR;
`endif

  modport slave (
    input  A_REQ, A_WE, A_LOCK, A_ADDR, A_WDATA,
    input  B_REQ, B_WE, B_LOCK, B_ADDR, B_WDATA,
    output A_GNT, A_RVALID, B_GNT, B_RVALID, RDATA,
    output RAM_ADDR, RAM_DIN, RAM_RI,
    input  RAM_DOUT
`ifdef RAM_ARB_WP_EN
    , input WP
    , output A_WERR
`endif
  );

  modport master (
    output A_REQ, A_WE, A_LOCK, A_ADDR, A_WDATA,
    output B_REQ, B_WE, B_LOCK, B_ADDR, B_WDATA,
    input  A_GNT, A_RVALID, B_GNT, B_RVALID, RDATA,
    input  RAM_ADDR, RAM_DIN, RAM_RI,
    output RAM_DOUT
`ifdef RAM_ARB_WP_EN
    , output WP
    , input A_WERR
`endif
  );

endinterface

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin picker with tie-break pointer and burst hold counter.
// While a port owns the bus only it can be granted; hold_hit flags the grant
// that uses up the owner's allowance while the other port is waiting.
module ram_arb_rr2
  import ram_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic own_a,     // current state is OWN_A
  input  logic own_b,     // current state is OWN_B
  input  logic keep_a,    // next state is OWN_A
  input  logic keep_b,    // next state is OWN_B
  output logic gnt_a,
  output logic gnt_b,
  output logic hold_hit
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  logic       ptr;
  logic [7:0] hold_cnt;
  logic [7:0] hold_inc;

  assign hold_inc = sat_inc(hold_cnt);

  // Pick the winner: owner only, else tie goes to the pointer's port.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (own_a) begin
      gnt_a = req_a;
    end else if (own_b) begin
      gnt_b = req_b;
    end else if (req_a && req_b) begin
      gnt_a = (ptr == PORT_A);
      gnt_b = (ptr == PORT_B);
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
  end

  // This grant brings the contested burst up to the limit.
  assign hold_hit = ((gnt_a && req_b) || (gnt_b && req_a)) && (hold_inc >= HOLD_LIM);

  // Pointer flips away from whoever was just served; counter tracks contested burst grants.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      ptr      <= PORT_A;
      hold_cnt <= '0;
    end else begin
      if (gnt_a)      ptr <= PORT_B;
      else if (gnt_b) ptr <= PORT_A;

      if (keep_a)      hold_cnt <= !req_b ? 8'd0 : (gnt_a ? hold_inc : hold_cnt);
      else if (keep_b) hold_cnt <= !req_a ? 8'd0 : (gnt_b ? hold_inc : hold_cnt);
      else             hold_cnt <= '0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing a single-port 16x8 RAM between port A (CPU) and port B
// (loader/debug): lock FSM, RAM address/data mux, 1-cycle read-valid pipeline.
// Optional: define RAM_ARB_WP_EN for per-bank write protection of port A.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = 8
) (
  input logic          CLK,
  input logic          RESETn,
  ram_arbiter_if.slave bus
);

  logic [1:0]        state, state_nxt;
  logic              a_req, b_req;
  logic              gnt_a, gnt_b, hold_hit;
  logic              own_a, own_b, keep_a, keep_b;
  logic              a_wp_hit;
  logic              rvalid_a, rvalid_b;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_din;

  // Requests are ignored while reset is held so nothing reaches the RAM.
  assign a_req  = bus.A_REQ & RESETn;
  assign b_req  = bus.B_REQ & RESETn;
  assign own_a  = (state == ST_OWN_A);
  assign own_b  = (state == ST_OWN_B);
  assign keep_a = (state_nxt == ST_OWN_A);
  assign keep_b = (state_nxt == ST_OWN_B);

  ram_arb_rr2 #(.MAX_HOLD(MAX_HOLD)) u_rr2 (
    .clk      (CLK),
    .rst_n    (RESETn),
    .req_a    (a_req),
    .req_b    (b_req),
    .own_a    (own_a),
    .own_b    (own_b),
    .keep_a   (keep_a),
    .keep_b   (keep_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .hold_hit (hold_hit)
  );

`ifdef RAM_ARB_WP_EN
  // Port A write into a protected bank: granted, but the RAM never sees it.
  assign a_wp_hit = bus.A_WE & bus.WP[bus.A_ADDR[ADDR_W-1]];
`else
  assign a_wp_hit = 1'b0;
`endif

  // Lock FSM: a locked grant takes ownership until lock drops or the hold limit trips.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gnt_a && bus.A_LOCK && !hold_hit)      state_nxt = ST_OWN_A;
        else if (gnt_b && bus.B_LOCK && !hold_hit) state_nxt = ST_OWN_B;
      end
      ST_OWN_A: if (!bus.A_LOCK || hold_hit) state_nxt = ST_IDLE;
      ST_OWN_B: if (!bus.B_LOCK || hold_hit) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset releases any lock in progress.
  always_ff @(posedge CLK) begin
    if (!RESETn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Route the granted port to the RAM; otherwise replay the last granted address/data.
  always_comb begin
    bus.RAM_ADDR = last_addr;
    bus.RAM_DIN  = last_din;
    bus.RAM_RI   = 1'b0;
    if (gnt_a) begin
      bus.RAM_ADDR = bus.A_ADDR;
      bus.RAM_DIN  = bus.A_WDATA;
      bus.RAM_RI   = bus.A_WE & ~a_wp_hit;
    end else if (gnt_b) begin
      bus.RAM_ADDR = bus.B_ADDR;
      bus.RAM_DIN  = bus.B_WDATA;
      bus.RAM_RI   = bus.B_WE;
    end
  end

  // Remember the last granted address/data and raise read-valid one cycle after a read grant.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      last_addr <= '0;
      last_din  <= '0;
      rvalid_a  <= 1'b0;
      rvalid_b  <= 1'b0;
    end else begin
      if (gnt_a || gnt_b) begin
        last_addr <= bus.RAM_ADDR;
        last_din  <= bus.RAM_DIN;
      end
      rvalid_a <= gnt_a & ~bus.A_WE;
      rvalid_b <= gnt_b & ~bus.B_WE;
    end
  end

`ifdef RAM_ARB_WP_EN
  logic a_werr;

  // One-cycle error pulse after a dropped protected write.
  always_ff @(posedge CLK) begin
    if (!RESETn) a_werr <= 1'b0;
    else         a_werr <= gnt_a & a_wp_hit;
  end

  assign bus.A_WERR = a_werr;
`endif

  assign bus.A_GNT    = gnt_a;
  assign bus.B_GNT    = gnt_b;
  assign bus.A_RVALID = rvalid_a;
  assign bus.B_RVALID = rvalid_b;
  // RAM output is already registered; gate it so RDATA reads zero when nothing is valid.
  assign bus.RDATA    = (rvalid_a || rvalid_b) ? bus.RAM_DOUT : '0;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 16x8 `ram` between two requesters: port A (CPU core) and port B (external loader/debug).
- Round-robin arbitration with optional per-requester bus lock for bursts.
- A hold-limit counter stops a locked owner from starving the other port.
- Sits between the requesters and `ram`. Drives ADDR/DIN/RI. Returns DOUT with a read-valid strobe.

Parameters:
- ADDR_W, 4, RAM address width (16 locations)
- DATA_W, 8, RAM data width
- MAX_HOLD, 8, max consecutive grants to a locked owner while the other port is requesting; 1..255

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESETn  in  1  synchronous reset, active-low
- A_REQ  in  1  port A access request
- A_WE  in  1  port A write (1) / read (0)
- A_LOCK  in  1  port A keeps ownership after its current grant
- A_ADDR  in  ADDR_W  port A address
- A_WDATA  in  DATA_W  port A write data
- A_GNT  out  1  port A access accepted this cycle
- A_RVALID  out  1  port A read data valid
- B_REQ, B_WE, B_LOCK, B_ADDR, B_WDATA  in  same as A, for port B
- B_GNT, B_RVALID  out  1  same as A, for port B
- RDATA  out  DATA_W  read data, shared by both ports; qualify with x_RVALID
- RAM_ADDR  out  ADDR_W  to ram ADDR
- RAM_DIN  out  DATA_W  to ram DIN
- RAM_RI  out  1  to ram RI (write enable)
- RAM_DOUT  in  DATA_W  from ram DOUT

Behaviour:
- Reset (RESETn=0 at an edge):
  - State=IDLE; round-robin pointer favours A; hold counter=0.
  - A_GNT=B_GNT=A_RVALID=B_RVALID=0, RAM_RI=0, RAM_ADDR=0, RAM_DIN=0, RDATA=0.
- Grant rules:
  - Combinational, same cycle as request; at most one GNT high.
  - x_GNT=1 means the RAM performs the access at the next rising edge.
  - RAM_ADDR, RAM_DIN and RAM_RI are driven combinationally from the granted port.
  - No grant: RAM_RI=0, RAM_ADDR/RAM_DIN hold their last granted values (registered copy).
- States:
  - IDLE:
    - Both requesting: grant the port the pointer favours; pointer flips to the other port.
    - One requesting: grant it; pointer flips to the other port.
    - Granted port has LOCK=1: next state OWN_A or OWN_B.
  - OWN_A:
    - Only A may be granted.
    - Exit to IDLE when A_LOCK=0 at a cycle's end, or when A_REQ=0 and A_LOCK=0.
    - Also exit to IDLE when hold counter reaches MAX_HOLD with B_REQ=1. The next arbitration then favours B regardless of A_LOCK.
  - OWN_B: symmetric to OWN_A.
- Hold counter:
  - Increments on each grant to the owner while the other port requests.
  - Clears on entry to IDLE or when the other port is not requesting.
  - Saturates; never wraps.
- Read latency: 1 cycle.
  - x_RVALID=1 in the cycle after a read grant; RDATA=RAM_DOUT registered-through (combinational from ram's registered output).
  - Writes produce no RVALID.
  - Back-to-back reads: one per cycle, RVALID pipelined.
- Simultaneous events:
  - Write grant to A with B requesting: B waits. A write then a read of the same address on consecutive cycles returns the new data.
  - REQ dropped by a requester in a cycle it would have been granted: no grant, no RAM access.
- Reset mid-operation: pending RVALID is squashed; a lock in progress is released.
- Address/data beyond widths: none possible; all 16 addresses legal. Bit 3 selects bank, transparent to this block.

Optional Feature:
- RAM_ARB_WP_EN defined:
  - Adds input WP[1:0]: bit0 write-protects bank0 (addr 0-7), bit1 bank1 (addr 8-15), against port A only.
  - A protected A write is still granted, but RAM_RI stays 0.
  - Adds output A_WERR, which pulses 1 for one cycle after the dropped write. A_WERR resets to 0.
  - Port B is never blocked.
- RAM_ARB_WP_EN undefined: no WP/A_WERR ports; all writes pass.

Decomposition:
- Shared package ram_arb_pkg: state enum (IDLE, OWN_A, OWN_B), port-index constants, default ADDR_W/DATA_W.
- One natural sub-module: ram_arb_rr2, the two-way round-robin picker with pointer and hold counter. The top level holds the FSM, RAM muxing and the RVALID pipeline.

Test Plan:
- Reset, then A_REQ read addr 5 (RAM[5]=0x3C): A_GNT=1 same cycle; next cycle A_RVALID=1, RDATA=0x3C; B_RVALID=0.
- A and B both request continuously, no lock:
  - Grants alternate A,B,A,B starting with A after reset.
  - B writes 0x11..0x14 to addr 8..11; memory checks pass.
- A locks with MAX_HOLD=8 while B requests: exactly 8 consecutive A grants, then B granted next cycle even with A_LOCK=1.
- Write then read: A writes 0xA5 to addr 15, next cycle A reads 15. Next cycle after the read grant: RDATA=0xA5.
- RESETn=0 during OWN_B with a read granted the previous cycle: B_RVALID=0, lock released, next arbitration favours A.
- RAM_ARB_WP_EN with WP=2'b10: A write 0x77 to addr 9 → RAM_RI=0, A_WERR pulse; B write 0x77 to addr 9 → RAM[9]=0x77.
